// File: rtl/ddr_wr_pkg.sv
// rtl/ddr_wr_pkg.sv - shared FSM state type, response code and beat-size helper for ddr_wr_stream_master
package ddr_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_t;

  localparam logic [1:0] DDR_RESP_OKAY = 2'b00;

  function automatic int beat_bytes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/ddr_wr_sfifo.sv
// rtl/ddr_wr_sfifo.sv - synchronous show-ahead FIFO with occupancy count
module ddr_wr_sfifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (cnt != '0);
  assign rdata   = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + AW'(1);
      if (do_pop)  rd_idx <= rd_idx + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ddr_wr_stream_master.sv
// rtl/ddr_wr_stream_master.sv - cuts a sample stream into fixed bursts written into a circular DDR region
// Optional statistics counters are enabled by defining DDR_WR_STAT_EN.
module ddr_wr_stream_master
  import ddr_wr_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int SIZE_WIDTH  = 16,
  parameter int BURST_BEATS = 64,
  parameter int FIFO_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_en,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_span,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  ddr_wreq_ready,
  output logic                  ddr_wreq_valid,
  output logic [ADDR_WIDTH-1:0] ddr_wreq_addr,
  output logic [SIZE_WIDTH-1:0] ddr_wreq_size,
  input  logic                  ddr_wdata_ready,
  output logic                  ddr_wdata_valid,
  output logic                  ddr_wdata_last,
  output logic [DATA_WIDTH-1:0] ddr_wdata,
  input  logic                  ddr_wresp_valid,
  input  logic [1:0]            ddr_wresp,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic                  busy,
  output logic                  err
`ifdef DDR_WR_STAT_EN
  ,
  output logic [31:0]           stat_bursts,
  output logic [15:0]           stat_errs
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BEAT_SH = $clog2(beat_bytes(DATA_WIDTH));
  localparam logic [CW-1:0] FULL_N = CW'(BURST_BEATS);

  wr_state_t             state, state_nx;
  logic                  en_q;
  logic                  flush_pend;
  logic                  fifo_full;
  logic [CW-1:0]         fifo_cnt;
  logic [CW-1:0]         n_q;
  logic [CW-1:0]         beat_cnt;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic [ADDR_WIDTH-1:0] base_q, span_q, next_ptr;
  logic [SIZE_WIDTH-1:0] burst_size;
  logic                  push, pop, start_full, start_flush, last_beat;

  assign s_ready     = !fifo_full && cfg_en;
  assign push        = s_valid && s_ready;
  assign pop         = ddr_wdata_valid && ddr_wdata_ready;
  assign start_full  = cfg_en && (fifo_cnt >= FULL_N);
  assign start_flush = cfg_en && flush_pend && (fifo_cnt != '0);
  assign last_beat   = (beat_cnt == n_q - CW'(1));
  assign burst_size  = SIZE_WIDTH'(n_q) << BEAT_SH;
  assign next_ptr    = wr_ptr + ADDR_WIDTH'(burst_size);

  ddr_wr_sfifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (s_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .cnt   (fifo_cnt),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start_full || start_flush)            state_nx = ST_REQ;
      ST_REQ:  if (ddr_wreq_ready)                       state_nx = ST_DATA;
      ST_DATA: if (pop && last_beat)                     state_nx = ST_RESP;
      ST_RESP: if (ddr_wresp_valid)                      state_nx = ST_IDLE;
      default:                                           state_nx = ST_IDLE;
    endcase
  end

  assign ddr_wreq_valid  = (state == ST_REQ);
  assign ddr_wreq_addr   = ddr_wreq_valid ? wr_ptr : '0;
  assign ddr_wreq_size   = ddr_wreq_valid ? burst_size : '0;
  assign ddr_wdata_valid = (state == ST_DATA);
  assign ddr_wdata_last  = ddr_wdata_valid && last_beat;
  assign ddr_wdata       = ddr_wdata_valid ? fifo_rdata : '0;
  assign busy            = (state != ST_IDLE) || (fifo_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q       <= 1'b0;
      flush_pend <= 1'b0;
      n_q        <= '0;
      beat_cnt   <= '0;
      base_q     <= '0;
      span_q     <= '0;
      wr_ptr     <= '0;
      err        <= 1'b0;
    end else begin
      en_q <= cfg_en;
      // A full burst takes priority; a pending flush then waits for the residue.
      if (flush && fifo_cnt != '0)
        flush_pend <= 1'b1;
      else if (state == ST_IDLE && ((start_flush && !start_full) || fifo_cnt == '0))
        flush_pend <= 1'b0;
      if (state == ST_IDLE && (start_full || start_flush))
        n_q <= start_full ? FULL_N : fifo_cnt;
      if (state == ST_REQ)
        beat_cnt <= '0;
      else if (pop)
        beat_cnt <= beat_cnt + CW'(1);
      if (state == ST_RESP && ddr_wresp_valid) begin
        if (ddr_wresp != DDR_RESP_OKAY) err <= 1'b1;
        wr_ptr <= (next_ptr >= base_q + span_q) ? base_q : next_ptr;
      end
      if (cfg_en && !en_q) begin
        base_q <= cfg_base;
        span_q <= cfg_span;
        wr_ptr <= cfg_base;
      end
    end
  end

`ifdef DDR_WR_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_bursts <= '0;
      stat_errs   <= '0;
    end else if (state == ST_RESP && ddr_wresp_valid) begin
      stat_bursts <= stat_bursts + 32'd1;
      if (ddr_wresp != DDR_RESP_OKAY && stat_errs != 16'hFFFF)
        stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_wr_stream_master.sv
// tb/tb_ddr_wr_stream_master.sv - randomized self-checking bench for ddr_wr_stream_master
module tb_ddr_wr_stream_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_en = 1'b0;
  logic [31:0] cfg_base = '0;
  logic [31:0] cfg_span = '0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic        ddr_wreq_ready;
  logic        ddr_wreq_valid;
  logic [31:0] ddr_wreq_addr;
  logic [15:0] ddr_wreq_size;
  logic        ddr_wdata_ready;
  logic        ddr_wdata_valid;
  logic        ddr_wdata_last;
  logic [63:0] ddr_wdata;
  logic        ddr_wresp_valid;
  logic [1:0]  ddr_wresp;
  logic [31:0] wr_ptr;
  logic        busy;
  logic        err;
`ifdef DDR_WR_STAT_EN
  logic [31:0] stat_bursts;
  logic [15:0] stat_errs;
`endif

  ddr_wr_stream_master dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_en          (cfg_en),
    .cfg_base        (cfg_base),
    .cfg_span        (cfg_span),
    .flush           (flush),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .ddr_wreq_ready  (ddr_wreq_ready),
    .ddr_wreq_valid  (ddr_wreq_valid),
    .ddr_wreq_addr   (ddr_wreq_addr),
    .ddr_wreq_size   (ddr_wreq_size),
    .ddr_wdata_ready (ddr_wdata_ready),
    .ddr_wdata_valid (ddr_wdata_valid),
    .ddr_wdata_last  (ddr_wdata_last),
    .ddr_wdata       (ddr_wdata),
    .ddr_wresp_valid (ddr_wresp_valid),
    .ddr_wresp       (ddr_wresp),
    .wr_ptr          (wr_ptr),
    .busy            (busy),
    .err             (err)
`ifdef DDR_WR_STAT_EN
    ,
    .stat_bursts     (stat_bursts),
    .stat_errs       (stat_errs)
`endif
  );

  always #2 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int resp_cnt = 0;
  int err_burst = -1;
  int stall_viol = 0;
  bit bp = 1'b0;

  logic [31:0] got_addr[$];
  logic [15:0] got_size[$];
  logic [63:0] got_data[$];
  bit          got_last[$];
  logic [63:0] exp_data[$];
  logic [31:0] m_base, m_span, m_ptr;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // DDR write-side slave: random readiness, one response per completed burst.
  initial begin
    bit resp_due = 0, req_hold = 0, dat_hold = 0, h_last = 0;
    logic [31:0] h_addr = '0;
    logic [15:0] h_size = '0;
    logic [63:0] h_data = '0;
    ddr_wreq_ready = 1'b0; ddr_wdata_ready = 1'b0;
    ddr_wresp_valid = 1'b0; ddr_wresp = 2'b00;
    forever begin
      @(negedge clk);
      ddr_wresp_valid = 1'b0;
      ddr_wresp = 2'b00;
      if (rst) begin
        resp_due = 0; req_hold = 0; dat_hold = 0;
      end else begin
        if (resp_due) begin
          ddr_wresp_valid = 1'b1;
          ddr_wresp = (resp_cnt == err_burst) ? 2'b10 : 2'b00;
          resp_cnt++;
          resp_due = 0;
        end
        ddr_wreq_ready  = bp ? ($urandom_range(0, 3) == 0) : 1'b1;
        ddr_wdata_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (req_hold && (!ddr_wreq_valid || ddr_wreq_addr != h_addr || ddr_wreq_size != h_size))
          stall_viol++;
        if (dat_hold && (!ddr_wdata_valid || ddr_wdata != h_data || ddr_wdata_last != h_last))
          stall_viol++;
        if (ddr_wreq_valid && ddr_wreq_ready) begin
          got_addr.push_back(ddr_wreq_addr);
          got_size.push_back(ddr_wreq_size);
        end
        if (ddr_wdata_valid && ddr_wdata_ready) begin
          got_data.push_back(ddr_wdata);
          got_last.push_back(ddr_wdata_last);
          if (ddr_wdata_last) resp_due = 1;
        end
        req_hold = ddr_wreq_valid && !ddr_wreq_ready;
        h_addr = ddr_wreq_addr; h_size = ddr_wreq_size;
        dat_hold = ddr_wdata_valid && !ddr_wdata_ready;
        h_data = ddr_wdata; h_last = ddr_wdata_last;
      end
    end
  end

  task automatic push_beats(input int cnt);
    int i = 0;
    int guard = 0;
    logic [63:0] d;
    d = {$urandom, $urandom};
    while (i < cnt && guard < cnt * 40 + 2000) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = d;
      if (s_ready) begin
        exp_data.push_back(d);
        i++;
        d = {$urandom, $urandom};
      end
      guard++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("push_done", i, cnt);
  endtask

  task automatic wait_resp(input int target);
    int g = 0;
    while (resp_cnt < target && g < 20000) begin
      @(negedge clk);
      g++;
    end
    check("resp_count", resp_cnt, target);
    repeat (2) @(negedge clk);
  endtask

  // Expected burst: address follows the ring model, size = n beats of 8 bytes, data in push order.
  task automatic expect_burst(input int n);
    logic [63:0] gd, ed;
    bit gl;
    check("req_avail", got_addr.size() > 0, 1);
    if (got_addr.size() > 0) begin
      check("req_addr", got_addr.pop_front(), m_ptr);
      check("req_size", got_size.pop_front(), n * 8);
    end
    m_ptr = m_ptr + n * 8;
    if (m_ptr >= m_base + m_span) m_ptr = m_base;
    check("beats_avail", (got_data.size() >= n) && (exp_data.size() >= n), 1);
    if (got_data.size() >= n && exp_data.size() >= n) begin
      for (int i = 0; i < n; i++) begin
        gd = got_data.pop_front();
        gl = got_last.pop_front();
        ed = exp_data.pop_front();
        check("beat_data", gd, ed);
        check("beat_last", gl, (i == n - 1));
      end
    end
  endtask

  task automatic enable_ring(input logic [31:0] base, input logic [31:0] span);
    @(negedge clk);
    cfg_en = 1'b0;
    @(negedge clk);
    check("s_ready_disabled", s_ready, 0);
    cfg_base = base; cfg_span = span; cfg_en = 1'b1;
    m_base = base; m_span = span; m_ptr = base;
    @(negedge clk);
    check("wr_ptr_load", wr_ptr, base);
  endtask

  initial begin
    int t, gd0, g;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wreq_valid", ddr_wreq_valid, 0);
    check("rst_wdata_valid", ddr_wdata_valid, 0);
    check("rst_last", ddr_wdata_last, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_addr_size_data", {ddr_wreq_addr, ddr_wreq_size, ddr_wdata}, 0);
    check("rst_wr_ptr", wr_ptr, 0);
    rst = 1'b0;

    // Test 1: one full burst
    enable_ring(32'h1000_0000, 32'h1000);
    push_beats(64);
    wait_resp(1);
    expect_burst(64);
    check("t1_wr_ptr", wr_ptr, m_ptr);
    check("t1_busy", busy, 0);

    // Test 2: nine bursts wrap the 4 KiB ring
    enable_ring(32'h1000_0000, 32'h1000);
    t = resp_cnt + 9;
    push_beats(9 * 64);
    wait_resp(t);
    for (int b = 0; b < 9; b++) expect_burst(64);
    check("t2_wr_ptr", wr_ptr, m_ptr);

    // Test 3: residual burst only on flush; flush with empty FIFO is dropped
    push_beats(10);
    repeat (20) @(negedge clk);
    check("t3_no_partial_req", got_addr.size(), 0);
    t = resp_cnt + 1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_resp(t);
    expect_burst(10);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (30) @(negedge clk);
    check("t3_empty_flush_req", got_addr.size(), 0);
    check("t3_empty_flush_resp", resp_cnt, t);
    check("t3_busy", busy, 0);

    // Test 4: random backpressure
    bp = 1'b1;
    t = resp_cnt + 100;
    push_beats(100 * 64);
    wait_resp(t);
    for (int b = 0; b < 100; b++) expect_burst(64);
    check("t4_stall_stable", stall_viol, 0);
    check("t4_no_extra_beats", got_data.size(), 0);
    check("t4_wr_ptr", wr_ptr, m_ptr);
    bp = 1'b0;

    // Test 5: error response on the third burst
    check("t5_err_before", err, 0);
    err_burst = resp_cnt + 2;
    t = resp_cnt + 4;
    push_beats(4 * 64);
    wait_resp(t);
    for (int b = 0; b < 4; b++) expect_burst(64);
    check("t5_err_set", err, 1);
    t = resp_cnt + 1;
    push_beats(64);
    wait_resp(t);
    expect_burst(64);
    check("t5_err_sticky", err, 1);
`ifdef DDR_WR_STAT_EN
    check("t5_stat_errs", stat_errs, 1);
`endif

    // Test 6: reset in the middle of a data phase
    push_beats(64);
    gd0 = got_data.size();
    g = 0;
    while (got_data.size() < gd0 + 19 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("t6_reach_beat20", got_data.size() >= gd0 + 19, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_wreq_valid", ddr_wreq_valid, 0);
    check("t6_wdata_valid", ddr_wdata_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_err", err, 0);
    check("t6_wr_ptr", wr_ptr, 0);
    rst = 1'b0;
    got_addr.delete(); got_size.delete(); got_data.delete(); got_last.delete();
    exp_data.delete();
    enable_ring(32'h2000_0000, 32'h800);
    t = resp_cnt + 1;
    push_beats(64);
    wait_resp(t);
    expect_burst(64);
    check("t6_wr_ptr_after", wr_ptr, m_ptr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
